sub64: RTL and testbench
========================

SUB64 -- requirements
Module: sub64

Interface
REQ-001 The block SHALL have no parameters; all data widths are fixed at 64 bits.
REQ-002 The port list SHALL be as follows, clock and reset first.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  64  minuend, two's-complement signed.
- b  input  64  subtrahend, two's-complement signed.
- in_valid  input  1  qualifies a/b for capture.
- sum  output  64  registered difference a - b, two's-complement signed.
- of  output  1  registered signed-overflow flag for the held result.
- out_valid  output  1  high when sum/of hold a result captured from in_valid.
REQ-003 The block SHALL use one clock, with reset asynchronous and active-low, exactly as listed for clk and rst_n.

Function
REQ-004 The difference SHALL be computed as a + (~b) + 1.
- 64-bit ripple-carry chain of explicit full-adder cells.
- Carry-in of bit 0 = 1.
- Result truncated to 64 bits; carry-out of bit 63 discarded.
REQ-005 Overflow SHALL be computed as: of_next = (a[63] != b[63]) AND (diff[63] != a[63]).
REQ-006 No other flag (carry, zero, sign) SHALL be output.
REQ-007 On a rising clk edge with in_valid=1, the block SHALL load sum<=diff and of<=of_next, and set out_valid<=1.
REQ-008 On a rising clk edge with in_valid=0, the block SHALL hold sum and of unchanged and set out_valid<=0.
REQ-009 Latency SHALL be exactly one cycle from the in_valid edge to the result.
- Throughput: one result per cycle.
- No backpressure.
- No combinational path from a/b to outputs.
REQ-010 Inputs a/b SHALL be sampled only at the capture edge; changes between edges SHALL NOT affect the outputs.
REQ-011 Wrap-around SHALL follow two's-complement modular arithmetic; e.g. min - 1 yields max with of=1.
REQ-012 Operand equality SHALL yield sum=0 and of=0, including a=b=0x8000000000000000.

Reset
REQ-013 While rst_n=0, the block SHALL force sum=0, of=0 and out_valid=0 immediately, independent of clk.
REQ-014 Deasserting rst_n SHALL take effect on the next rising clk edge.
- in_valid=1 at that edge loads a result normally.
REQ-015 Asserting rst_n mid-stream SHALL discard any in-flight capture; no partial result appears after reset.

Verification
REQ-016 The bench SHALL check a=1, b=3, in_valid=1 -> next cycle sum=0xFFFFFFFFFFFFFFFE (-2), of=0, out_valid=1.
REQ-017 The bench SHALL check a=10, b=21 -> sum=-11 (0xFFFFFFFFFFFFFFF5), of=0.
REQ-018 The bench SHALL check a=546, b=7 -> sum=539, of=0.
REQ-019 The bench SHALL check a=0x7FFFFFFFFFFFFFFF, b=~1 (0xFFFFFFFFFFFFFFFE) -> sum=0x8000000000000001, of=1.
REQ-020 The bench SHALL check a=0x8000000000000000, b=1 -> sum=0x7FFFFFFFFFFFFFFF, of=1; then in_valid=0 for 3 cycles -> sum/of held, out_valid=0.
REQ-021 The bench SHALL check that asserting rst_n=0 between clk edges after a loaded result forces sum=0, of=0, out_valid=0 before the next edge.

Source files
------------

// File: rtl/sub64.sv
// sub64: registered 64-bit two's-complement subtractor (a - b) built as a
// ripple chain of full-adder cells, with a signed-overflow flag.
module sub64_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module sub64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        in_valid,
    output logic [63:0] sum,
    output logic        of,
    output logic        out_valid
);
    logic [63:0] b_inv;
    logic [63:0] diff;
    logic [63:0] carry;
    logic        carry_out_unused;
    logic        of_next;

    logic [63:0] sum_q, sum_d;
    logic        of_q, of_d;
    logic        valid_q, valid_d;

    assign b_inv    = ~b;
    // Subtraction as a + ~b + 1: the +1 enters as the chain's carry-in.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < 64; i++) begin : g_chain
        if (i < 63) begin : g_mid
            sub64_fa u_fa (
                .a_i (a[i]),
                .b_i (b_inv[i]),
                .c_i (carry[i]),
                .s_o (diff[i]),
                .c_o (carry[i+1])
            );
        end else begin : g_top
            sub64_fa u_fa (
                .a_i (a[i]),
                .b_i (b_inv[i]),
                .c_i (carry[i]),
                .s_o (diff[i]),
                .c_o (carry_out_unused)
            );
        end
    end

    assign of_next = (a[63] != b[63]) && (diff[63] != a[63]);

    always_comb begin
        sum_d   = sum_q;
        of_d    = of_q;
        valid_d = 1'b0;
        if (in_valid) begin
            sum_d   = diff;
            of_d    = of_next;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            of_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            of_q    <= of_d;
            valid_q <= valid_d;
        end
    end

    assign sum       = sum_q;
    assign of        = of_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_sub64.sv
// tb_sub64: directed-vector bench for sub64 with hand-computed expectations.
module tb_sub64;
    logic        clk;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        in_valid;
    logic [63:0] sum;
    logic        of;
    logic        out_valid;

    int total;
    int bad;

    sub64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .sum       (sum),
        .of        (of),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic drive(input logic [63:0] av, input logic [63:0] bv, input logic v);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 64'h1234;
        b = 64'h5678;
        in_valid = 1'b1;
        #2;
        total++;
        if ({sum, of, out_valid} !== {64'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got sum=%h of=%b ov=%b want sum=0 of=0 ov=0", sum, of, out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if ({sum, of, out_valid} !== {64'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_held_over_edge: got sum=%h of=%b ov=%b want 0/0/0", sum, of, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] av [3] = '{64'd1, 64'd10, 64'd546};
        logic [63:0] bv [3] = '{64'd3, 64'd21, 64'd7};
        logic [63:0] ev [3] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF5, 64'd539};
        for (int i = 0; i < 3; i++) begin
            drive(av[i], bv[i], 1'b1);
            total++;
            if ({sum, of, out_valid} !== {ev[i], 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL basic[%0d]: got sum=%h of=%b ov=%b want sum=%h of=0 ov=1",
                         i, sum, of, out_valid, ev[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] av [4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic [63:0] bv [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1};
        logic [63:0] ev [4] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
        logic        eo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(av[i], bv[i], 1'b1);
            total++;
            if ({sum, of, out_valid} !== {ev[i], eo[i], 1'b1}) begin
                bad++;
                $display("FAIL overflow[%0d]: got sum=%h of=%b ov=%b want sum=%h of=%b ov=1",
                         i, sum, of, out_valid, ev[i], eo[i]);
            end
        end
        // Idle cycles with garbage operands must hold min-1 = max, of=1.
        for (int i = 0; i < 3; i++) begin
            drive(64'hDEAD_BEEF_0000_0001 + 64'(i), 64'h5555, 1'b0);
            total++;
            if ({sum, of, out_valid} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL hold[%0d]: got sum=%h of=%b ov=%b want sum=7fffffffffffffff of=1 ov=0",
                         i, sum, of, out_valid);
            end
        end
    endtask

    task automatic test_equality();
        logic [63:0] v [3] = '{64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        drive(64'd5, 64'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(v[i], v[i], 1'b1);
            total++;
            if ({sum, of, out_valid} !== {64'h0, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL equal[%0d]: got sum=%h of=%b ov=%b want sum=0 of=0 ov=1",
                         i, sum, of, out_valid);
            end
        end
    endtask

    task automatic test_input_isolation();
        drive(64'd100, 64'd1, 1'b1);
        #2;
        a = 64'hFFFF_0000_FFFF_0000;
        b = 64'h1;
        #1;
        total++;
        if ({sum, of, out_valid} !== {64'd99, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL isolation_midcycle: got sum=%h of=%b ov=%b want sum=63 of=0 ov=1", sum, of, out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if ({sum, of, out_valid} !== {64'hFFFF_0000_FFFE_FFFF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL isolation_next: got sum=%h of=%b ov=%b want sum=ffff0000fffeffff of=0 ov=1", sum, of, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] av [4] = '{64'd50, 64'd0, 64'h8000_0000_0000_0000, 64'd7};
        logic [63:0] bv [4] = '{64'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7};
        logic [63:0] ev [4] = '{64'd42, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'd0};
        for (int i = 0; i < 4; i++) begin
            drive(av[i], bv[i], 1'b1);
            total++;
            if ({sum, of, out_valid} !== {ev[i], 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL b2b[%0d]: got sum=%h of=%b ov=%b want sum=%h of=0 ov=1",
                         i, sum, of, out_valid, ev[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(64'h8000_0000_0000_0000, 64'd1, 1'b1);
        // Assert reset at the falling edge, with a capture pending for the next rising edge.
        a = 64'd20;
        b = 64'd3;
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({sum, of, out_valid} !== {64'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got sum=%h of=%b ov=%b want 0/0/0", sum, of, out_valid);
        end
        @(posedge clk);
        #1;
        total++;
        if ({sum, of, out_valid} !== {64'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_discard: got sum=%h of=%b ov=%b want 0/0/0", sum, of, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({sum, of, out_valid} !== {64'd17, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release_load: got sum=%h of=%b ov=%b want sum=11 of=0 ov=1", sum, of, out_valid);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_equality();
        test_input_isolation();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
